// File: rtl/sc_reg_shift_pkg.sv
// Shared constants for the parallel-in/serial-out shift stage:
// FSM state encoding and default geometry.
package sc_reg_shift_pkg;

    typedef enum logic {
        STATE_IDLE  = 1'b0,
        STATE_SHIFT = 1'b1
    } state_e;

    localparam int DATAWIDTH_BUS_DEF = 32;
    localparam int CNT_WIDTH_DEF     = 6;

endpackage

// File: rtl/sc_reg_shift.sv
// Purpose: serialize one DATAWIDTH_BUS-bit word, MSB or LSB first, with bit-valid and last flags.
// Latency: first bit valid the cycle after capture; W bit cycles per word, then one idle cycle.
// Backpressure: ready only in IDLE; load while busy is ignored, upstream holds load until ready.
module sc_reg_shift
    import sc_reg_shift_pkg::*;
#(
    parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
    parameter bit MSB_FIRST     = 1'b1,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                     SC_RegSHIFT_CLOCK_50,
    input  logic                     SC_RegSHIFT_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegSHIFT_data_InBUS,
    input  logic                     SC_RegSHIFT_load_InHigh,
    input  logic                     SC_RegSHIFT_abort_InHigh,
    output logic                     SC_RegSHIFT_ready_OutHigh,
    output logic                     SC_RegSHIFT_serial_Out,
    output logic                     SC_RegSHIFT_bitvalid_OutHigh,
    output logic                     SC_RegSHIFT_last_OutHigh
);

    state_e                   state_q, state_d;
    logic [DATAWIDTH_BUS-1:0] sreg_q, sreg_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     out_bit;

    assign out_bit = MSB_FIRST ? sreg_q[DATAWIDTH_BUS-1] : sreg_q[0];

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (SC_RegSHIFT_abort_InHigh) begin
            // Abort keeps the partially shifted word; only the FSM and counter are cleared.
            state_d = STATE_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (SC_RegSHIFT_load_InHigh) begin
                        state_d = STATE_SHIFT;
                        sreg_d  = SC_RegSHIFT_data_InBUS;
                        cnt_d   = CNT_WIDTH'(DATAWIDTH_BUS - 1);
                    end
                end
                STATE_SHIFT: begin
                    if (MSB_FIRST) begin
                        sreg_d = {sreg_q[DATAWIDTH_BUS-2:0], 1'b0};
                    end else begin
                        sreg_d = {1'b0, sreg_q[DATAWIDTH_BUS-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = STATE_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = STATE_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(negedge SC_RegSHIFT_CLOCK_50 or negedge SC_RegSHIFT_RESET_InLow) begin
        if (!SC_RegSHIFT_RESET_InLow) begin
            state_q <= STATE_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Serial output is gated so a stale word left by an abort never leaks out in IDLE.
    always_comb begin
        SC_RegSHIFT_ready_OutHigh    = (state_q == STATE_IDLE);
        SC_RegSHIFT_bitvalid_OutHigh = (state_q == STATE_SHIFT);
        SC_RegSHIFT_serial_Out       = (state_q == STATE_SHIFT) && out_bit;
        SC_RegSHIFT_last_OutHigh     = (state_q == STATE_SHIFT) && (cnt_q == '0);
    end

endmodule

// File: tb/tb_sc_reg_shift.sv
// Randomized and directed bench for sc_reg_shift; MSB-first and LSB-first instances
// share stimulus and are checked against a per-word queue of expected bits.
module tb_sc_reg_shift;

    localparam int W = 32;

    logic          clk   = 1'b1;
    logic          rst_n = 1'b1;
    logic [W-1:0]  data  = '0;
    logic          load  = 1'b0;
    logic          abort = 1'b0;

    logic rdy_m, ser_m, bv_m, last_m;
    logic rdy_l, ser_l, bv_l, last_l;

    int n_checks = 0;
    int n_errors = 0;

    bit qm[$];
    bit ql[$];

    int           nbits;
    logic [W-1:0] rec_m, rec_l;

    always #10 clk = ~clk;

    sc_reg_shift #(.DATAWIDTH_BUS(W), .MSB_FIRST(1'b1), .CNT_WIDTH(6)) u_msb (
        .SC_RegSHIFT_CLOCK_50         (clk),
        .SC_RegSHIFT_RESET_InLow      (rst_n),
        .SC_RegSHIFT_data_InBUS       (data),
        .SC_RegSHIFT_load_InHigh      (load),
        .SC_RegSHIFT_abort_InHigh     (abort),
        .SC_RegSHIFT_ready_OutHigh    (rdy_m),
        .SC_RegSHIFT_serial_Out       (ser_m),
        .SC_RegSHIFT_bitvalid_OutHigh (bv_m),
        .SC_RegSHIFT_last_OutHigh     (last_m)
    );

    sc_reg_shift #(.DATAWIDTH_BUS(W), .MSB_FIRST(1'b0), .CNT_WIDTH(6)) u_lsb (
        .SC_RegSHIFT_CLOCK_50         (clk),
        .SC_RegSHIFT_RESET_InLow      (rst_n),
        .SC_RegSHIFT_data_InBUS       (data),
        .SC_RegSHIFT_load_InHigh      (load),
        .SC_RegSHIFT_abort_InHigh     (abort),
        .SC_RegSHIFT_ready_OutHigh    (rdy_l),
        .SC_RegSHIFT_serial_Out       (ser_l),
        .SC_RegSHIFT_bitvalid_OutHigh (bv_l),
        .SC_RegSHIFT_last_OutHigh     (last_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("ready_m",    32'(rdy_m),  32'(qm.size() == 0));
        chk("ready_l",    32'(rdy_l),  32'(ql.size() == 0));
        chk("bitvalid_m", 32'(bv_m),   32'(qm.size() != 0));
        chk("bitvalid_l", 32'(bv_l),   32'(ql.size() != 0));
        chk("last_m",     32'(last_m), 32'(qm.size() == 1));
        chk("last_l",     32'(last_l), 32'(ql.size() == 1));
        if (qm.size() != 0) chk("serial_m", 32'(ser_m), 32'(qm[0]));
        if (ql.size() != 0) chk("serial_l", 32'(ser_l), 32'(ql[0]));
        if (bv_m === 1'b1) begin
            rec_m = {rec_m[W-2:0], ser_m};
            rec_l = {ser_l, rec_l[W-1:1]};
            nbits++;
        end
    endtask

    // One clock: check at the rising edge (mid-cycle), then drive for the next falling edge.
    task automatic cycle(input logic ld, input logic [W-1:0] d, input logic ab);
        @(posedge clk);
        check_outputs();
        load  = ld;
        data  = d;
        abort = ab;
        if (ab) begin
            qm.delete();
            ql.delete();
        end else if (qm.size() == 0) begin
            if (ld) begin
                for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
                for (int i = 0; i < W; i++)      ql.push_back(d[i]);
            end
        end else begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        abort = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        chk("rst_ready",    32'(rdy_m), 32'd1);
        chk("rst_bitvalid", 32'(bv_m),  32'd0);
        chk("rst_serial",   32'(ser_m), 32'd0);
        chk("rst_last",     32'(last_m), 32'd0);
        chk("rst_ready_l",  32'(rdy_l), 32'd1);
        @(negedge clk);
        #2;
        chk("rst_hold_bitvalid", 32'(bv_l), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic word_test(input string tag, input logic [W-1:0] w);
        nbits = 0;
        rec_m = '0;
        rec_l = '0;
        cycle(1'b1, w, 1'b0);
        idle_cycles(W + 2);
        chk({tag, "_nbits"}, 32'(nbits), 32'(W));
        chk({tag, "_msb_word"}, rec_m, w);
        chk({tag, "_lsb_word"}, rec_l, w);
    endtask

    initial begin
        #2;
        do_reset();
        idle_cycles(2);

        word_test("msb_a5", 32'hA500_0001);
        word_test("lsb_03", 32'h0000_0003);

        // Load held high across a busy word: second word waits for the idle cycle.
        cycle(1'b1, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
        idle_cycles(W + 2);

        // Abort at bit 10.
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
        idle_cycles(10);
        cycle(1'b0, '0, 1'b1);
        idle_cycles(3);

        // Abort together with load in IDLE.
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
        idle_cycles(2);

        // Reset in the middle of a word.
        cycle(1'b1, 32'hCAFE_F00D, 1'b0);
        idle_cycles(5);
        @(posedge clk);
        do_reset();
        idle_cycles(2);

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 99) < 3));
        end
        idle_cycles(W + 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
